// File: rtl/watch_pkg.sv
// Shared constants for the stopwatch display path.
//   NUM_DIGITS      : number of multiplexed 7-segment digits
//   SEG_*           : active-high segment patterns, bit order gfedcba
//   DP_MASK         : digits whose decimal point is lit (M M. S S. m m)
//   DIG_*           : digit positions inside the 24-bit BCD display buffer
//   digit_of()      : extract one BCD nibble from the buffer by scan index
package watch_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Points follow minutes (digit 4) and seconds (digit 2).
  localparam logic [5:0] DP_MASK = 6'b010100;

  // Buffer layout: digit 5 is the leftmost (tens of minutes).
  localparam digit_idx_t DIG_MSEC1 = 3'd0;
  localparam digit_idx_t DIG_MSEC2 = 3'd1;
  localparam digit_idx_t DIG_SEC0  = 3'd2;
  localparam digit_idx_t DIG_SEC1  = 3'd3;
  localparam digit_idx_t DIG_MIN0  = 3'd4;
  localparam digit_idx_t DIG_MIN1  = 3'd5;
  localparam digit_idx_t DIG_LAST  = DIG_MIN1;

  function automatic logic [3:0] digit_of(input logic [23:0] dbuf, input digit_idx_t idx);
    logic [3:0] nib;
    nib = 4'h0;
    case (idx)
      DIG_MSEC1: nib = dbuf[3:0];
      DIG_MSEC2: nib = dbuf[7:4];
      DIG_SEC0:  nib = dbuf[11:8];
      DIG_SEC1:  nib = dbuf[15:12];
      DIG_MIN0:  nib = dbuf[19:16];
      DIG_MIN1:  nib = dbuf[23:20];
      default:   nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i     : 4-bit digit code
//   pattern_o : active-high segment pattern (gfedcba); codes above 9 give a dash
module seg7_decode
  import watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] pattern_o
);

  always_comb begin
    pattern_o = SEG_DASH;
    case (bcd_i)
      4'd0:    pattern_o = SEG_0;
      4'd1:    pattern_o = SEG_1;
      4'd2:    pattern_o = SEG_2;
      4'd3:    pattern_o = SEG_3;
      4'd4:    pattern_o = SEG_4;
      4'd5:    pattern_o = SEG_5;
      4'd6:    pattern_o = SEG_6;
      4'd7:    pattern_o = SEG_7;
      4'd8:    pattern_o = SEG_8;
      4'd9:    pattern_o = SEG_9;
      default: pattern_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/watch_disp_scan.sv
// Time-multiplexed driver for a 6-digit common-anode 7-segment display.
// Each digit is lit for DWELL_TICKS cycles; the display buffer is sampled once
// per frame (on the digit 5 -> digit 0 wrap) so a frame never mixes two times.
//   clk_1Khz : system clock, rising edge
//   rst      : asynchronous active-high reset, all outputs inactive
//   dispbuf  : BCD digits, [23:20] = digit 5 (leftmost) .. [3:0] = digit 0
//   blank    : 1 = all anodes off while scanning continues
//   seg      : segments a..g on seg[0]..seg[6]
//   dp       : decimal point of the current digit
//   an       : anode enables, an[i] drives digit i
// DWELL_TICKS must be within 1..255.
module watch_disp_scan
  import watch_pkg::*;
#(
  parameter int unsigned DWELL_TICKS    = 2,
  parameter bit          LZ_BLANK       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_1Khz,
  input  logic        rst,
  input  logic [23:0] dispbuf,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an
);

  localparam logic [7:0] DwellLast = 8'(DWELL_TICKS - 1);

  // Output levels for "nothing lit".
  localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DpOff  = SEG_ACTIVE_LOW;
  localparam logic [5:0] AnOff  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [7:0]  dwell_q, dwell_d;
  digit_idx_t  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  an_q, an_d;

  logic        dwell_last;
  logic        frame_end;
  logic [3:0]  cur_digit;
  logic [6:0]  dec_pattern;
  logic [6:0]  pattern;
  logic        dp_lit;
  logic [5:0]  an_onehot;

  // Scan timing and frame snapshot.
  always_comb begin
    dwell_last = (dwell_q == DwellLast);
    frame_end  = dwell_last && (idx_q == DIG_LAST);

    dwell_d = dwell_last ? 8'd0 : dwell_q + 8'd1;

    idx_d = idx_q;
    if (dwell_last) begin
      idx_d = frame_end ? 3'd0 : idx_q + 3'd1;
    end

    // The new buffer is taken on the same edge that returns to digit 0, so
    // digit 0 of the next frame is the first to show it.
    snap_d = frame_end ? dispbuf : snap_q;
  end

  assign cur_digit = digit_of(snap_q, idx_q);

  seg7_decode u_seg7_decode (
    .bcd_i     (cur_digit),
    .pattern_o (dec_pattern)
  );

  // Output next-state, computed from the current index and registered.
  always_comb begin
    pattern = dec_pattern;
    // Leading zero on tens-of-minutes: segments dark, anode still driven.
    if (LZ_BLANK && (idx_q == DIG_MIN1) && (cur_digit == 4'd0)) begin
      pattern = SEG_BLANK;
    end

    dp_lit    = DP_MASK[idx_q];
    an_onehot = blank ? 6'h00 : (6'b000001 << idx_q);

    seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    an_d  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
  end

  always_ff @(posedge clk_1Khz or posedge rst) begin
    if (rst) begin
      dwell_q <= 8'd0;
      idx_q   <= 3'd0;
      snap_q  <= 24'h0;
      seg_q   <= SegOff;
      dp_q    <= DpOff;
      an_q    <= AnOff;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_watch_disp_scan.sv
// Scoreboard bench for watch_disp_scan. Three instances with different
// parameter sets share one stimulus stream. Per edge, the expected outputs of
// all three are computed from a frame-arithmetic model and queued; a monitor
// on the falling edge pops and compares.
module tb_watch_disp_scan;

  localparam int unsigned NI = 3;
  localparam int unsigned DT0 = 2;
  localparam int unsigned DT1 = 3;
  localparam int unsigned DT2 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] dispbuf = 24'h0;
  logic        blank = 1'b0;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [5:0] an0, an1, an2;

  always #5 clk = ~clk;

  watch_disp_scan #(
    .DWELL_TICKS(DT0), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u0 (
    .clk_1Khz(clk), .rst(rst), .dispbuf(dispbuf), .blank(blank),
    .seg(seg0), .dp(dp0), .an(an0)
  );

  watch_disp_scan #(
    .DWELL_TICKS(DT1), .LZ_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u1 (
    .clk_1Khz(clk), .rst(rst), .dispbuf(dispbuf), .blank(blank),
    .seg(seg1), .dp(dp1), .an(an1)
  );

  watch_disp_scan #(
    .DWELL_TICKS(DT2), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u2 (
    .clk_1Khz(clk), .rst(rst), .dispbuf(dispbuf), .blank(blank),
    .seg(seg2), .dp(dp2), .an(an2)
  );

  // {an, dp, seg} per instance.
  logic [13:0] act [NI];
  assign act[0] = {an0, dp0, seg0};
  assign act[1] = {an1, dp1, seg1};
  assign act[2] = {an2, dp2, seg2};

  int unsigned dt_a  [NI] = '{DT0, DT1, DT2};
  bit          lz_a  [NI] = '{1'b1, 1'b0, 1'b1};
  bit          sal_a [NI] = '{1'b1, 1'b1, 1'b0};
  bit          aal_a [NI] = '{1'b1, 1'b1, 1'b0};

  logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state: cycles since reset release, and the frame snapshot.
  int unsigned t_m    [NI];
  logic [23:0] snap_m [NI];

  logic [41:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic logic [13:0] inactive(input int i);
    logic [6:0] s;
    logic [5:0] a;
    s = sal_a[i] ? 7'h7F : 7'h00;
    a = aal_a[i] ? 6'h3F : 6'h00;
    return {a, sal_a[i], s};
  endfunction

  function automatic logic [13:0] exp_out(input int i, input int idx, input logic [23:0] sn,
                                          input logic bl);
    logic [3:0] d;
    logic [6:0] p;
    logic       pt;
    logic [5:0] a;
    d  = 4'((sn >> (4 * idx)) & 24'hF);
    p  = (d <= 4'd9) ? pat_tbl[d] : 7'h40;
    if (lz_a[i] && idx == 5 && d == 4'd0) p = 7'h00;
    pt = (idx == 4) || (idx == 2);
    a  = bl ? 6'h00 : 6'(1 << idx);
    if (sal_a[i]) begin
      p  = ~p;
      pt = ~pt;
    end
    if (aal_a[i]) a = ~a;
    return {a, pt, p};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got an=%h dp=%b seg=%h, want an=%h dp=%b seg=%h",
               name, cyc, got[13:8], got[7], got[6:0], want[13:8], want[7], want[6:0]);
    end
  endtask

  // Advance the model by one rising edge, queueing the outputs it predicts.
  task automatic model_edge();
    logic [41:0] e;
    int fr;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        e[i*14 +: 14] = inactive(i);
        t_m[i]    = 0;
        snap_m[i] = 24'h0;
      end else begin
        fr = 6 * dt_a[i];
        e[i*14 +: 14] = exp_out(i, (t_m[i] / dt_a[i]) % 6, snap_m[i], blank);
        if (t_m[i] % fr == fr - 1) snap_m[i] = dispbuf;
        t_m[i] = (t_m[i] + 1) % fr;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [23:0] d, input logic b, input logic r);
    @(negedge clk);
    #1;
    dispbuf = d;
    blank   = b;
    if (r && !rst) begin
      // Reset must clear outputs without waiting for a clock edge.
      rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) check($sformatf("async_rst_u%0d", i), act[i], inactive(i));
    end
    rst = r;
    @(posedge clk);
    cyc++;
    model_edge();
  endtask

  function automatic logic [23:0] rand_buf();
    logic [23:0] v;
    for (int k = 0; k < 6; k++) begin
      v[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 3) == 0) v[23:20] = 4'h0;
    return v;
  endfunction

  // Monitor: one queued expectation per rising edge, compared mid-cycle.
  always @(negedge clk) begin
    logic [41:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < NI; i++) check($sformatf("scan_u%0d", i), act[i], e[i*14 +: 14]);
    end
  end

  initial begin
    logic [23:0] cur_d;
    logic        cur_b;
    cur_d = 24'h0;
    cur_b = 1'b0;

    for (int k = 0; k < 3; k++) step(24'h0, 1'b0, 1'b1);

    // Two frames of the slowest instance on a fixed value.
    for (int k = 0; k < 2 * 6 * DT1; k++) step(24'h123456, 1'b0, 1'b0);

    // Leading zero plus an invalid code on digit 4.
    for (int k = 0; k < 2 * 6 * DT1; k++) step(24'h0A9999, 1'b0, 1'b0);

    // Blank pulse of 5 cycles.
    for (int k = 0; k < 5; k++) step(24'h0A9999, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(24'h011111, 1'b0, 1'b0);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) cur_d = rand_buf();
      if ($urandom_range(0, 15) == 0) cur_b = ~cur_b;
      if (c == 500 || $urandom_range(0, 299) == 0) step(cur_d, cur_b, 1'b1);
      else step(cur_d, cur_b, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
